// File: rtl/acq_sequencer_if.sv
// Control/status bundle between the acquisition controller and acq_sequencer.
// master = controller/packer side, slave = sequencer.
interface acq_sequencer_if;
    logic        Start;
    logic        Stop;
    logic        UpdateReq;
    logic [15:0] FrameTarget;
    logic [31:0] CfgIn_1;
    logic [31:0] CfgIn_2;
    logic        FrameEnd;
    logic        DataWriteEnable;
    logic        FifoAlmostFull;
    logic [31:0] CONFIG_REG_1;
    logic [31:0] CONFIG_REG_2;
    logic        PackerRst;
    logic        Busy;
    logic        Done;
    logic        Overflow;
    logic        Timeout;
    logic [15:0] FramesDone;

    modport master (
        output Start, Stop, UpdateReq, FrameTarget, CfgIn_1, CfgIn_2,
               FrameEnd, DataWriteEnable, FifoAlmostFull,
        input  CONFIG_REG_1, CONFIG_REG_2, PackerRst, Busy, Done,
               Overflow, Timeout, FramesDone
    );

    modport slave (
        input  Start, Stop, UpdateReq, FrameTarget, CfgIn_1, CfgIn_2,
               FrameEnd, DataWriteEnable, FifoAlmostFull,
        output CONFIG_REG_1, CONFIG_REG_2, PackerRst, Busy, Done,
               Overflow, Timeout, FramesDone
    );
endinterface

// File: rtl/acq_sequencer.sv
// Acquisition run sequencer: arms the packer, counts frames, applies config at frame
// boundaries. Optional frame watchdog enabled by defining ACQ_WATCHDOG_EN.
module acq_sequencer (
    input  logic           InputClock,
    input  logic           rst,
    acq_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  arm_cnt_q, arm_cnt_d;
    logic [15:0] frames_q, frames_d;
    logic [31:0] cfg1_q, cfg1_d, cfg2_q, cfg2_d;
    logic        pend_q, pend_d;
    logic        ovf_q, ovf_d;
    logic        packer_rst_q, busy_q, done_q;
    logic        active;
`ifdef ACQ_WATCHDOG_EN
    logic [19:0] wd_q, wd_d;
    logic        tmo_q, tmo_d;
`endif

    assign active = (state_q == RUN) || (state_q == DRAIN);

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        frames_d  = frames_q;
        cfg1_d    = cfg1_q;
        cfg2_d    = cfg2_q;
        pend_d    = pend_q;
        ovf_d     = ovf_q;
`ifdef ACQ_WATCHDOG_EN
        wd_d      = wd_q;
        tmo_d     = tmo_q;
`endif

        // Config only moves on a frame boundary so the packer never sees a mid-frame change
        if (active && bus.FrameEnd) begin
            frames_d = frames_q + 16'd1;
            if (pend_q || bus.UpdateReq) begin
                cfg1_d = bus.CfgIn_1;
                cfg2_d = bus.CfgIn_2;
                pend_d = 1'b0;
            end
        end else if ((state_q == ARM || active) && bus.UpdateReq) begin
            pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                arm_cnt_d = 2'd0;
                if (bus.Start) begin
                    state_d  = ARM;
                    cfg1_d   = bus.CfgIn_1;
                    cfg2_d   = bus.CfgIn_2;
                    frames_d = 16'd0;
                    ovf_d    = 1'b0;
                    pend_d   = 1'b0;
`ifdef ACQ_WATCHDOG_EN
                    tmo_d    = 1'b0;
`endif
                end
            end
            ARM: begin
                arm_cnt_d = arm_cnt_q + 2'd1;
                if (arm_cnt_q == 2'd3) state_d = RUN;
            end
            RUN: begin
                if (bus.FrameEnd && (bus.Stop ||
                    (bus.FrameTarget != 16'd0 && frames_d == bus.FrameTarget)))
                    state_d = DONE;
                else if (bus.Stop)
                    state_d = DRAIN;
            end
            DRAIN: if (bus.FrameEnd) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef ACQ_WATCHDOG_EN
        if (state_q == ARM) wd_d = 20'd0;
        else if (active)    wd_d = bus.FrameEnd ? 20'd0 : wd_q + 20'd1;
        if (active && !bus.FrameEnd && wd_q == 20'hFFFFF) begin
            tmo_d   = 1'b1;
            state_d = DONE;
        end
`endif

        // Overflow wins over every other transition
        if (active && bus.DataWriteEnable && bus.FifoAlmostFull) begin
            ovf_d   = 1'b1;
            state_d = DONE;
        end
    end

    always_ff @(posedge InputClock) begin
        if (rst) begin
            state_q      <= IDLE;
            arm_cnt_q    <= 2'd0;
            frames_q     <= 16'd0;
            cfg1_q       <= 32'd0;
            cfg2_q       <= 32'd0;
            pend_q       <= 1'b0;
            ovf_q        <= 1'b0;
            packer_rst_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef ACQ_WATCHDOG_EN
            wd_q         <= 20'd0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            arm_cnt_q    <= arm_cnt_d;
            frames_q     <= frames_d;
            cfg1_q       <= cfg1_d;
            cfg2_q       <= cfg2_d;
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
            packer_rst_q <= (state_d == IDLE) || (state_d == ARM);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
`ifdef ACQ_WATCHDOG_EN
            wd_q         <= wd_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign bus.CONFIG_REG_1 = cfg1_q;
    assign bus.CONFIG_REG_2 = cfg2_q;
    assign bus.PackerRst    = packer_rst_q;
    assign bus.Busy         = busy_q;
    assign bus.Done         = done_q;
    assign bus.Overflow     = ovf_q;
    assign bus.FramesDone   = frames_q;
`ifdef ACQ_WATCHDOG_EN
    assign bus.Timeout      = tmo_q;
`else
    assign bus.Timeout      = 1'b0;
`endif
endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: randomized runs checked against expectations
// derived from frame counts, cycle timing and the config-update rules.
module tb_acq_sequencer;
    logic InputClock = 1'b0;
    logic rst;
    acq_sequencer_if bus();

    acq_sequencer dut (.InputClock(InputClock), .rst(rst), .bus(bus));

    always #5 InputClock = ~InputClock;

    int n_chk = 0;
    int n_pass = 0;

    task automatic tick();
        @(posedge InputClock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Start = 0; bus.Stop = 0; bus.UpdateReq = 0; bus.FrameEnd = 0;
        bus.DataWriteEnable = 0; bus.FifoAlmostFull = 0;
    endtask

    task automatic frame_pulse();
        bus.FrameEnd = 1; tick(); bus.FrameEnd = 0;
    endtask

    // Pulses Start and reports Busy after one edge and the edge count until PackerRst drops
    task automatic start_run(input logic [15:0] tgt, input logic [31:0] c1, input logic [31:0] c2,
                             output int lat, output logic busy1);
        bus.FrameTarget = tgt; bus.CfgIn_1 = c1; bus.CfgIn_2 = c2;
        bus.Start = 1; tick(); bus.Start = 0;
        busy1 = bus.Busy;
        lat = 1;
        while (bus.PackerRst !== 1'b0 && lat < 20) begin tick(); lat++; end
    endtask

    task automatic finish_run();
        bus.Stop = 1; bus.FrameEnd = 1; tick(); clear_inputs(); tick();
    endtask

    task automatic test_reset();
        clear_inputs(); bus.FrameTarget = 0; bus.CfgIn_1 = 32'hA5A5A5A5; bus.CfgIn_2 = 32'h5A5A5A5A;
        rst = 1; tick(); tick();
        n_chk++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.Busy); else n_pass++;
        n_chk++; if (bus.Done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.Done); else n_pass++;
        n_chk++; if (bus.PackerRst !== 1'b1) $display("FAIL reset_packerrst: got %b want 1", bus.PackerRst); else n_pass++;
        n_chk++; if ({bus.Overflow, bus.Timeout} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {bus.Overflow, bus.Timeout}); else n_pass++;
        n_chk++; if (bus.FramesDone !== 16'd0) $display("FAIL reset_frames: got %0d want 0", bus.FramesDone); else n_pass++;
        n_chk++; if ({bus.CONFIG_REG_1, bus.CONFIG_REG_2} !== 64'd0) $display("FAIL reset_cfg: got %h want 0", {bus.CONFIG_REG_1, bus.CONFIG_REG_2}); else n_pass++;
        rst = 0; tick();
    endtask

    task automatic test_target_run();
        for (int it = 0; it < 4; it++) begin
            logic [15:0] tgt, exp_f;
            logic [31:0] c1, c2;
            int gap, lat;
            logic b1;
            tgt = (it == 0) ? 16'd3 : 16'($urandom_range(1, 5));
            gap = (it == 0) ? 100 : $urandom_range(2, 30);
            c1 = $urandom; c2 = $urandom;
            start_run(tgt, c1, c2, lat, b1);
            n_chk++; if (b1 !== 1'b1) $display("FAIL tgt_busy_latency: got %b want 1", b1); else n_pass++;
            n_chk++; if (lat != 5) $display("FAIL tgt_packerrst_release: got %0d want 5", lat); else n_pass++;
            n_chk++; if ({bus.CONFIG_REG_1, bus.CONFIG_REG_2} !== {c1, c2}) $display("FAIL tgt_cfg_latched: got %h want %h", {bus.CONFIG_REG_1, bus.CONFIG_REG_2}, {c1, c2}); else n_pass++;
            n_chk++; if (bus.FramesDone !== 16'd0) $display("FAIL tgt_frames_cleared: got %0d want 0", bus.FramesDone); else n_pass++;
            exp_f = 0;
            for (int k = 1; k <= int'(tgt); k++) begin
                repeat (gap - 1) tick();
                frame_pulse();
                exp_f++;
                if (k < int'(tgt)) begin
                    n_chk++; if ({bus.Done, bus.FramesDone} !== {1'b0, exp_f}) $display("FAIL tgt_midrun: done/frames got %b/%0d want 0/%0d", bus.Done, bus.FramesDone, exp_f); else n_pass++;
                end else begin
                    n_chk++; if ({bus.Done, bus.FramesDone} !== {1'b1, tgt}) $display("FAIL tgt_done: done/frames got %b/%0d want 1/%0d", bus.Done, bus.FramesDone, tgt); else n_pass++;
                end
            end
            tick();
            n_chk++; if ({bus.Done, bus.Busy, bus.PackerRst} !== 3'b001) $display("FAIL tgt_idle: done/busy/prst got %b want 001", {bus.Done, bus.Busy, bus.PackerRst}); else n_pass++;
            repeat (3) tick();
            n_chk++; if ({bus.FramesDone, bus.Timeout} !== {tgt, 1'b0}) $display("FAIL tgt_hold: frames/tmo got %0d/%b want %0d/0", bus.FramesDone, bus.Timeout, tgt); else n_pass++;
        end
    endtask

    task automatic test_stop_drain();
        for (int it = 0; it < 3; it++) begin
            logic [15:0] nf;
            int lat;
            logic b1;
            nf = (it == 0) ? 16'd2 : 16'($urandom_range(1, 4));
            start_run(16'd0, $urandom, $urandom, lat, b1);
            for (int k = 0; k < int'(nf); k++) begin repeat ($urandom_range(3, 25)) tick(); frame_pulse(); end
            if (it == 2) begin
                bus.Stop = 1; bus.FrameEnd = 1; tick(); clear_inputs();
                n_chk++; if ({bus.Done, bus.FramesDone} !== {1'b1, nf + 16'd1}) $display("FAIL stop_coincident: done/frames got %b/%0d want 1/%0d", bus.Done, bus.FramesDone, nf + 16'd1); else n_pass++;
            end else begin
                repeat ((it == 0) ? 49 : $urandom_range(2, 20)) tick();
                bus.Stop = 1; tick(); bus.Stop = 0;
                n_chk++; if ({bus.Busy, bus.Done} !== 2'b10) $display("FAIL stop_drain_entry: busy/done got %b want 10", {bus.Busy, bus.Done}); else n_pass++;
                repeat (4) tick();
                bus.Start = 1; bus.Stop = 1; tick(); clear_inputs(); tick();
                n_chk++; if ({bus.Busy, bus.Done, bus.FramesDone} !== {2'b10, nf}) $display("FAIL drain_ignores_start_stop: busy/done/frames got %b%b/%0d want 10/%0d", bus.Busy, bus.Done, bus.FramesDone, nf); else n_pass++;
                repeat ($urandom_range(2, 20)) tick();
                frame_pulse();
                n_chk++; if ({bus.Done, bus.FramesDone} !== {1'b1, nf + 16'd1}) $display("FAIL drain_done: done/frames got %b/%0d want 1/%0d", bus.Done, bus.FramesDone, nf + 16'd1); else n_pass++;
            end
            tick();
            n_chk++; if (bus.Busy !== 1'b0) $display("FAIL stop_idle: busy got %b want 0", bus.Busy); else n_pass++;
        end
    endtask

    task automatic test_update();
        for (int it = 0; it < 3; it++) begin
            logic [31:0] exp1, exp2, nv;
            int lat;
            logic b1;
            exp1 = $urandom; exp2 = $urandom;
            start_run(16'd0, exp1, exp2, lat, b1);
            bus.CfgIn_1 = $urandom; bus.CfgIn_2 = $urandom;
            repeat ($urandom_range(3, 10)) tick();
            frame_pulse();
            n_chk++; if ({bus.CONFIG_REG_1, bus.CONFIG_REG_2} !== {exp1, exp2}) $display("FAIL upd_no_pending: got %h want %h", {bus.CONFIG_REG_1, bus.CONFIG_REG_2}, {exp1, exp2}); else n_pass++;
            repeat ($urandom_range(2, 8)) tick();
            nv = (it == 0) ? 32'h12345678 : $urandom;
            bus.CfgIn_1 = $urandom; bus.UpdateReq = 1; tick(); bus.UpdateReq = 0;
            repeat ($urandom_range(2, 8)) tick();
            bus.CfgIn_1 = nv;
            repeat ($urandom_range(1, 8)) tick();
            n_chk++; if (bus.CONFIG_REG_1 !== exp1) $display("FAIL upd_mid_frame: got %h want %h", bus.CONFIG_REG_1, exp1); else n_pass++;
            exp1 = nv; exp2 = bus.CfgIn_2;
            frame_pulse();
            n_chk++; if ({bus.CONFIG_REG_1, bus.CONFIG_REG_2} !== {exp1, exp2}) $display("FAIL upd_at_frame: got %h want %h", {bus.CONFIG_REG_1, bus.CONFIG_REG_2}, {exp1, exp2}); else n_pass++;
            repeat ($urandom_range(2, 8)) tick();
            nv = $urandom; bus.CfgIn_1 = nv; exp1 = nv;
            bus.UpdateReq = 1; bus.FrameEnd = 1; tick(); clear_inputs();
            n_chk++; if (bus.CONFIG_REG_1 !== exp1) $display("FAIL upd_coincident: got %h want %h", bus.CONFIG_REG_1, exp1); else n_pass++;
            finish_run();
        end
    endtask

    task automatic test_overflow();
        for (int it = 0; it < 3; it++) begin
            int lat;
            logic b1;
            start_run(16'd0, $urandom, $urandom, lat, b1);
            n_chk++; if (bus.Overflow !== 1'b0) $display("FAIL ovf_cleared_by_start: got %b want 0", bus.Overflow); else n_pass++;
            repeat ($urandom_range(0, 2)) begin repeat ($urandom_range(2, 10)) tick(); frame_pulse(); end
            bus.DataWriteEnable = 1; tick(); clear_inputs();
            bus.FifoAlmostFull = 1; tick(); clear_inputs();
            n_chk++; if ({bus.Busy, bus.Overflow} !== 2'b10) $display("FAIL ovf_single_flag: busy/ovf got %b want 10", {bus.Busy, bus.Overflow}); else n_pass++;
            bus.DataWriteEnable = 1; bus.FifoAlmostFull = 1; bus.Stop = ($urandom_range(0, 1) == 1); tick(); clear_inputs();
            n_chk++; if ({bus.Overflow, bus.Done} !== 2'b11) $display("FAIL ovf_done: ovf/done got %b want 11", {bus.Overflow, bus.Done}); else n_pass++;
            tick();
            bus.DataWriteEnable = 1; bus.FifoAlmostFull = 1; tick(); clear_inputs();
            n_chk++; if ({bus.Busy, bus.Done, bus.Overflow} !== 3'b001) $display("FAIL ovf_sticky_idle: busy/done/ovf got %b want 001", {bus.Busy, bus.Done, bus.Overflow}); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic b1;
        start_run(16'd0, $urandom | 32'h1, $urandom | 32'h1, lat, b1);
        repeat (2) begin repeat ($urandom_range(2, 10)) tick(); frame_pulse(); end
        n_chk++; if (bus.FramesDone !== 16'd2) $display("FAIL rst_run_precond: frames got %0d want 2", bus.FramesDone); else n_pass++;
        repeat (3) tick();
        rst = 1; tick(); rst = 0;
        n_chk++; if ({bus.Busy, bus.Done, bus.PackerRst, bus.FramesDone} !== {3'b001, 16'd0}) $display("FAIL rst_run_state: busy/done/prst/frames got %b/%0d want 001/0", {bus.Busy, bus.Done, bus.PackerRst}, bus.FramesDone); else n_pass++;
        n_chk++; if ({bus.CONFIG_REG_1, bus.CONFIG_REG_2} !== 64'd0) $display("FAIL rst_run_cfg: got %h want 0", {bus.CONFIG_REG_1, bus.CONFIG_REG_2}); else n_pass++;
        repeat (3) tick();
        n_chk++; if (bus.Busy !== 1'b0) $display("FAIL rst_run_stays_idle: busy got %b want 0", bus.Busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic b1;
        logic [31:0] c1;
        c1 = $urandom;
        bus.Stop = 1;
        start_run(16'd2, c1, $urandom, lat, b1);
        bus.Stop = 0;
        n_chk++; if ({b1, lat == 5} !== 2'b11) $display("FAIL b2b_start_stop_as_start: busy/lat got %b/%0d want 1/5", b1, lat); else n_pass++;
        repeat (4) tick(); frame_pulse();
        bus.Start = 1; bus.CfgIn_1 = ~c1; tick(); bus.Start = 0;
        n_chk++; if ({bus.FramesDone, bus.CONFIG_REG_1, bus.PackerRst} !== {16'd1, c1, 1'b0}) $display("FAIL b2b_start_in_run: frames/cfg/prst got %0d/%h/%b want 1/%h/0", bus.FramesDone, bus.CONFIG_REG_1, bus.PackerRst, c1); else n_pass++;
        repeat (4) tick(); frame_pulse();
        bus.Start = 1; tick(); bus.Start = 0;
        n_chk++; if ({bus.Done, bus.Busy} !== 2'b00) $display("FAIL b2b_start_in_done: done/busy got %b want 00", {bus.Done, bus.Busy}); else n_pass++;
        start_run(16'd1, c1, 32'd0, lat, b1);
        n_chk++; if ({b1, lat == 5, bus.FramesDone} !== {2'b11, 16'd0}) $display("FAIL b2b_restart: busy/lat/frames got %b/%0d/%0d want 1/5/0", b1, lat, bus.FramesDone); else n_pass++;
        frame_pulse(); tick();
    endtask

    task automatic test_watchdog();
        int lat;
        logic b1;
        start_run(16'd0, $urandom, $urandom, lat, b1);
`ifdef ACQ_WATCHDOG_EN
        begin
            int cyc;
            cyc = 0;
            while (bus.Done !== 1'b1 && cyc < (1 << 20) + 16) begin tick(); cyc++; end
            n_chk++; if (bus.Timeout !== 1'b1 || cyc < (1 << 20) - 2 || cyc > (1 << 20) + 2) $display("FAIL wd_timeout: tmo/cycles got %b/%0d want 1/~%0d", bus.Timeout, cyc, 1 << 20); else n_pass++;
            tick();
        end
`else
        repeat (3000) tick();
        n_chk++; if ({bus.Busy, bus.Done, bus.Timeout, bus.PackerRst} !== 4'b1000) $display("FAIL wd_absent: busy/done/tmo/prst got %b want 1000", {bus.Busy, bus.Done, bus.Timeout, bus.PackerRst}); else n_pass++;
        finish_run();
`endif
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        bus.FrameTarget = 0; bus.CfgIn_1 = 0; bus.CfgIn_2 = 0;
        test_reset();
        test_target_run();
        test_stop_drain();
        test_update();
        test_overflow();
        test_reset_mid_run();
        test_back_to_back();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Reset rst SHALL be synchronous and active-high; clock SHALL be InputClock.
REQ-002 Ports SHALL be:
- InputClock  in  1  ADC sample clock
- rst  in  1  synchronous active-high reset
- Start  in  1  one-cycle pulse; begin acquisition
- Stop  in  1  one-cycle pulse; end after current frame
- UpdateReq  in  1  one-cycle pulse; request config reload at next frame boundary
- FrameTarget  in  16  frames per run; 0 = continuous
- CfgIn_1  in  32  staged value for CONFIG_REG_1
- CfgIn_2  in  32  staged value for CONFIG_REG_2
- FrameEnd  in  1  one-cycle pulse from packer at frame wrap
- DataWriteEnable  in  1  packer data-FIFO write strobe
- FifoAlmostFull  in  1  data FIFO almost-full flag
- CONFIG_REG_1  out  32  applied config to packer
- CONFIG_REG_2  out  32  applied config to packer
- PackerRst  out  1  holds the packer in reset
- Busy  out  1  high in any state other than IDLE
- Done  out  1  one-cycle completion pulse
- Overflow  out  1  sticky overflow flag
- Timeout  out  1  sticky watchdog flag
- FramesDone  out  16  frames completed in the current run

Function
REQ-003 FSM states SHALL be IDLE, ARM, RUN, DRAIN and DONE.
REQ-004 IDLE: PackerRst=1; a Start pulse latches CfgIn_1/2 into CONFIG_REG_1/2, clears FramesDone, Overflow, Timeout and the pending-update flag, then enters ARM.
REQ-005 ARM: PackerRst SHALL stay 1 for exactly 4 cycles, then the FSM enters RUN; PackerRst SHALL be 0 from the first RUN cycle.
REQ-006 RUN: each FrameEnd SHALL increment FramesDone, which wraps 0xFFFF->0 with no flag.
REQ-007 RUN, target reached: FrameEnd with FrameTarget!=0 and FramesDone+1==FrameTarget SHALL go to DONE.
REQ-008 RUN, Stop: Stop SHALL go to DRAIN; Stop coincident with FrameEnd SHALL count the frame and go directly to DONE.
REQ-009 DRAIN: the next FrameEnd SHALL increment FramesDone and go to DONE; Stop and Start SHALL be ignored.
REQ-010 DONE: Done=1 for exactly one cycle, then IDLE; FramesDone and the sticky flags SHALL hold until the next accepted Start.
REQ-011 UpdateReq in ARM, RUN or DRAIN SHALL set a pending flag.
- At the next FrameEnd, CfgIn_1/2 SHALL load into CONFIG_REG_1/2 and the flag SHALL clear.
- UpdateReq coincident with FrameEnd SHALL load on that same edge.
- CONFIG_REG_* SHALL never change mid-frame while RUN or DRAIN.
REQ-012 Overflow: in RUN or DRAIN, DataWriteEnable=1 and FifoAlmostFull=1 in the same cycle SHALL set Overflow and go to DONE next cycle, regardless of other inputs.
REQ-013 Start outside IDLE SHALL be ignored; Start and Stop together in IDLE SHALL act as Start only.
REQ-014 All outputs SHALL be registered; Start-to-Busy latency SHALL be 1 cycle.

Reset
REQ-015 rst SHALL force the following, at any state, on the next edge:
- state IDLE
- PackerRst=1
- Busy=0, Done=0
- Overflow=0, Timeout=0
- FramesDone=0
- CONFIG_REG_1/2=0
- pending-update flag cleared.

Configuration
REQ-016 Macro ACQ_WATCHDOG_EN controls the watchdog.
- Defined: a 20-bit counter clears on entry to RUN and on every FrameEnd and increments in RUN/DRAIN; reaching 0xFFFFF SHALL set Timeout and go to DONE.
- Undefined: Timeout tied 0 and no counter logic.

Verification
REQ-017 FrameTarget=3, Start, FrameEnd every 100 cycles -> PackerRst low 5 cycles after Start; Done at the 3rd FrameEnd +1 cycle; FramesDone=3.
REQ-018 FrameTarget=0, Stop 50 cycles after the 2nd FrameEnd -> DRAIN; Done one cycle after the 3rd FrameEnd; FramesDone=3.
REQ-019 CfgIn_1=0x12345678 after Start, UpdateReq mid-frame -> CONFIG_REG_1 unchanged until FrameEnd; equals 0x12345678 from the next cycle.
REQ-020 DataWriteEnable and FifoAlmostFull both high in RUN -> Overflow=1, Done pulse, IDLE; the next Start clears Overflow.
REQ-021 rst asserted during RUN with FramesDone=2 -> next cycle IDLE, FramesDone=0, PackerRst=1, CONFIG_REG_*=0.
REQ-022 With ACQ_WATCHDOG_EN defined, no FrameEnd after RUN entry -> Timeout=1 after 2^20-1 cycles and Done pulse; without the macro, no Timeout and the FSM stays in RUN.
